// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction-fetch sequencer.
//
// Owns the program counter and runs a single-outstanding request/ack
// handshake with instruction memory of arbitrary latency. A fetched word
// is presented to the IF/ID register in the cycle after its ack. It is held
// there while the consumer stalls. It is then either handed off (counted) or
// squashed by a branch. Branches that arrive while a request is in flight
// are remembered and applied when that request completes, so the request
// address never changes under an outstanding request.
//
// Every output is decoded from a register; there are no in->out paths.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   stall_i        downstream cannot take inst_o this cycle
//   br_en_i        one-cycle redirect pulse, target in br_target_i
//   br_target_i    redirect address (bits [1:0] forced to 0)
//   imem_req_o     memory request valid
//   imem_addr_o    request address (held until ack)
//   imem_ack_i     memory returns imem_rdata_i this cycle
//   imem_rdata_i   fetched instruction word
//   ce_o           fetch enable, low only while in reset
//   inst_valid_o   inst_o / inst_pc_o valid
//   inst_o         fetched instruction
//   inst_pc_o      address inst_o was fetched from
//   fetch_cnt_o    number of instructions handed off (wraps)
module fetch_ctrl #(
    parameter int unsigned     AW       = 32,
    parameter int unsigned     IW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_i,
    input  logic          br_en_i,
    input  logic [AW-1:0] br_target_i,
    output logic          imem_req_o,
    output logic [AW-1:0] imem_addr_o,
    input  logic          imem_ack_i,
    input  logic [IW-1:0] imem_rdata_i,
    output logic          ce_o,
    output logic          inst_valid_o,
    output logic [IW-1:0] inst_o,
    output logic [AW-1:0] inst_pc_o,
    output logic [31:0]   fetch_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          ce_q, ce_d;
    logic [IW-1:0] inst_q, inst_d;
    logic [AW-1:0] inst_pc_q, inst_pc_d;
    logic [31:0]   fetch_cnt_q, fetch_cnt_d;
    logic          redir_pend_q, redir_pend_d;
    logic [AW-1:0] redir_tgt_q, redir_tgt_d;

    // Branch target with the byte offset cleared, keeping pc word aligned.
    logic [AW-1:0] br_tgt_al;
    assign br_tgt_al = br_target_i & ~{{(AW-2){1'b0}}, 2'b11};

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the
        // case below can leave a signal unassigned and infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        ce_d         = 1'b1;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        fetch_cnt_d  = fetch_cnt_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_WAIT;
                if (br_en_i) begin
                    pc_d = br_tgt_al;
                end
            end

            S_WAIT: begin
                if (imem_ack_i) begin
                    if (br_en_i || redir_pend_q) begin
                        // Returned word belongs to the abandoned path: drop
                        // it and refetch; a same-cycle branch wins.
                        pc_d         = br_en_i ? br_tgt_al : redir_tgt_q;
                        redir_pend_d = 1'b0;
                    end else begin
                        inst_d    = imem_rdata_i;
                        inst_pc_d = pc_q;
                        pc_d      = pc_q + AW'(4);
                        state_d   = S_VALID;
                    end
                end else if (br_en_i) begin
                    // Keep the address stable; apply the target on ack.
                    redir_pend_d = 1'b1;
                    redir_tgt_d  = br_tgt_al;
                end
            end

            S_VALID: begin
                if (br_en_i) begin
                    pc_d    = br_tgt_al;
                    state_d = S_WAIT;
                end else if (!stall_i) begin
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                    state_d     = S_WAIT;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            ce_q         <= 1'b0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            fetch_cnt_q  <= '0;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ce_q         <= ce_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            fetch_cnt_q  <= fetch_cnt_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
        end
    end

    assign imem_req_o   = (state_q == S_WAIT);
    assign imem_addr_o  = pc_q;
    assign ce_o         = ce_q;
    assign inst_valid_o = (state_q == S_VALID);
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign fetch_cnt_o  = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl -- directed self-checking bench for fetch_ctrl.
//
// Inputs are driven and outputs sampled on the falling clock edge. A small
// memory model supplies instruction words; every accepted fetch pushes its
// expected {pc, inst} into a scoreboard that is popped when the instruction
// appears on the output.
module tb_fetch_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned IW = 32;
    localparam logic [AW-1:0] RESET_PC = 32'h0000_0000;

    logic          clk;
    logic          rst;
    logic          stall_i;
    logic          br_en_i;
    logic [AW-1:0] br_target_i;
    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic          imem_ack_i;
    logic [IW-1:0] imem_rdata_i;
    logic          ce_o;
    logic          inst_valid_o;
    logic [IW-1:0] inst_o;
    logic [AW-1:0] inst_pc_o;
    logic [31:0]   fetch_cnt_o;

    fetch_ctrl #(.AW(AW), .IW(IW), .RESET_PC(RESET_PC)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .br_en_i      (br_en_i),
        .br_target_i  (br_target_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_ack_i   (imem_ack_i),
        .imem_rdata_i (imem_rdata_i),
        .ce_o         (ce_o),
        .inst_valid_o (inst_valid_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .fetch_cnt_o  (fetch_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
    } exp_t;

    exp_t        sb[$];
    int          vecs = 0;
    int          errs = 0;
    logic [31:0] exp_cnt = '0;

    function automatic logic [IW-1:0] mem(input logic [AW-1:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete fetch of 'addr': wait for the request, ack after 'lat'
    // extra cycles, check the delivered word, hold it for 'stall_n' stalled
    // cycles, then hand it off or (do_br) squash it with a branch to br_tgt.
    // Ends on the falling edge where the next request is expected.
    task automatic fetch(input logic [AW-1:0] addr, input int lat, input int stall_n,
                         input logic do_br, input logic [AW-1:0] br_tgt);
        int   k;
        exp_t e;
        k = 0;
        while (!imem_req_o && k < 8) begin
            @(negedge clk);
            k++;
        end
        check("req_seen", {31'b0, imem_req_o}, 32'd1);
        for (int i = 0; i < lat; i++) begin
            check("addr_hold", imem_addr_o, addr);
            @(negedge clk);
            check("req_hold", {31'b0, imem_req_o}, 32'd1);
        end
        check("req_addr", imem_addr_o, addr);
        imem_ack_i   = 1'b1;
        imem_rdata_i = mem(addr);
        sb.push_back('{pc: addr, inst: mem(addr)});
        @(negedge clk);
        imem_ack_i   = 1'b0;
        imem_rdata_i = '0;
        check("valid", {31'b0, inst_valid_o}, 32'd1);
        check("no_req_in_valid", {31'b0, imem_req_o}, 32'd0);
        check("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("inst", inst_o, e.inst);
            check("inst_pc", inst_pc_o, e.pc);
            stall_i = (stall_n > 0);
            for (int s = 0; s < stall_n; s++) begin
                @(negedge clk);
                check("stall_valid", {31'b0, inst_valid_o}, 32'd1);
                check("stall_inst", inst_o, e.inst);
                check("stall_pc", inst_pc_o, e.pc);
                check("stall_noreq", {31'b0, imem_req_o}, 32'd0);
                check("stall_cnt", fetch_cnt_o, exp_cnt);
            end
        end
        if (do_br) begin
            br_en_i     = 1'b1;
            br_target_i = br_tgt;
            @(negedge clk);
            br_en_i = 1'b0;
            stall_i = 1'b0;
            check("squash_valid", {31'b0, inst_valid_o}, 32'd0);
            check("squash_req", {31'b0, imem_req_o}, 32'd1);
            check("squash_addr", imem_addr_o, br_tgt & ~32'h3);
            check("squash_cnt", fetch_cnt_o, exp_cnt);
        end else begin
            stall_i = 1'b0;
            @(negedge clk);
            exp_cnt = exp_cnt + 32'd1;
            check("handoff_valid", {31'b0, inst_valid_o}, 32'd0);
            check("handoff_req", {31'b0, imem_req_o}, 32'd1);
            check("handoff_cnt", fetch_cnt_o, exp_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst          = 1'b1;
        stall_i      = 1'b0;
        br_en_i      = 1'b0;
        br_target_i  = '0;
        imem_ack_i   = 1'b0;
        imem_rdata_i = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_req", {31'b0, imem_req_o}, 32'd0);
        check("rst_ce", {31'b0, ce_o}, 32'd0);
        check("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        check("rst_inst", inst_o, 32'd0);
        check("rst_inst_pc", inst_pc_o, 32'd0);
        check("rst_cnt", fetch_cnt_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ce_after_rst", {31'b0, ce_o}, 32'd1);

        // Sequential fetch, one delayed ack held at 0x8.
        fetch(32'h0, 0, 0, 1'b0, '0);
        fetch(32'h4, 0, 0, 1'b0, '0);
        fetch(32'h8, 3, 0, 1'b0, '0);
        fetch(32'hC, 0, 0, 1'b0, '0);
        check("cnt_after_4", fetch_cnt_o, 32'd4);

        // Branch while waiting on 0x10; late ack data is dropped.
        check("wait_addr_10", imem_addr_o, 32'h10);
        br_en_i     = 1'b1;
        br_target_i = 32'h103;
        @(negedge clk);
        br_en_i = 1'b0;
        check("redir_addr_stable", imem_addr_o, 32'h10);
        @(negedge clk);
        check("redir_addr_stable2", imem_addr_o, 32'h10);
        imem_ack_i   = 1'b1;
        imem_rdata_i = mem(32'h10);
        @(negedge clk);
        imem_ack_i   = 1'b0;
        imem_rdata_i = '0;
        check("redir_no_valid", {31'b0, inst_valid_o}, 32'd0);
        check("redir_req", {31'b0, imem_req_o}, 32'd1);
        check("redir_addr", imem_addr_o, 32'h100);
        fetch(32'h100, 0, 0, 1'b0, '0);

        // Same-cycle branch on ack beats an older pending target.
        br_en_i     = 1'b1;
        br_target_i = 32'h200;
        @(negedge clk);
        br_target_i  = 32'h300;
        imem_ack_i   = 1'b1;
        imem_rdata_i = mem(32'h104);
        @(negedge clk);
        br_en_i      = 1'b0;
        imem_ack_i   = 1'b0;
        imem_rdata_i = '0;
        check("prio_no_valid", {31'b0, inst_valid_o}, 32'd0);
        check("prio_addr", imem_addr_o, 32'h300);

        // Stall 5 cycles, then branch under stall to a misaligned target.
        fetch(32'h300, 0, 5, 1'b1, 32'hFFFF_FFFE);

        // PC wrap at the top of memory, and counter wrap on handoff.
        dut.fetch_cnt_q = 32'hFFFF_FFFF;
        exp_cnt         = 32'hFFFF_FFFF;
        fetch(32'hFFFF_FFFC, 0, 0, 1'b0, '0);
        check("cnt_wrap", fetch_cnt_o, 32'd0);
        check("pc_wrap_addr", imem_addr_o, 32'h0);
        fetch(32'h0, 1, 0, 1'b0, '0);

        // Reset while a request is outstanding.
        check("pre_rst_req", {31'b0, imem_req_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_req", {31'b0, imem_req_o}, 32'd0);
        check("mid_rst_ce", {31'b0, ce_o}, 32'd0);
        check("mid_rst_valid", {31'b0, inst_valid_o}, 32'd0);
        check("mid_rst_cnt", fetch_cnt_o, 32'd0);
        rst     = 1'b0;
        exp_cnt = '0;
        fetch(RESET_PC, 0, 0, 1'b0, '0);
        check("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
